// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one single-port memory bus between a CPU master (0) and a DMA master (1)
// using req/done handshakes, round-robin or fixed priority with a starvation guard for master 1.
module data_bus_arbiter #(
   parameter int MEM_LAT   = 1,
   parameter int PRIO_MODE = 0,
   parameter int MAX_WAIT  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req_i,
   input  logic        m0_wr_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_done_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_stall_o,
   input  logic        m1_req_i,
   input  logic        m1_wr_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_done_o,
   output logic [31:0] m1_rdata_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          wr_q, wr_d;
   logic          last_q, last_d;
   logic [1:0]    done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WW-1:0] wait1_q, wait1_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata0_q, rdata0_d;
   logic [31:0]   rdata1_q, rdata1_d;
   logic          busy, req0, req1, arb, win1, fin;

   assign busy = state_q == ACCESS;
   assign req0 = m0_req_i & ~done_q[0];
   assign req1 = m1_req_i & ~done_q[1];
   // no grant in a done cycle, so each transfer takes MEM_LAT+2 cycles
   assign arb  = ~busy & ~|done_q & (req0 | req1);
   assign win1 = req1 & (~req0 | ((PRIO_MODE != 0) ? (wait1_q >= WW'(MAX_WAIT)) : ~last_q));
   assign fin  = busy & (cnt_q == CW'(MEM_LAT - 1));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      last_d   = last_q;
      done_d   = 2'b00;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      wait1_d  = (arb & win1) ? '0 :
                 (req1 & ~(busy & owner_q) & (wait1_q < WW'(MAX_WAIT))) ? wait1_q + WW'(1) : wait1_q;
      if (arb) begin
         state_d = ACCESS;
         owner_d = win1;
         wr_d    = win1 ? m1_wr_i : m0_wr_i;
         addr_d  = win1 ? m1_addr_i : m0_addr_i;
         wdata_d = win1 ? m1_wdata_i : m0_wdata_i;
         cnt_d   = '0;
      end else if (busy) begin
         cnt_d = cnt_q + CW'(1);
         if (fin) begin
            state_d = IDLE;
            last_d  = owner_q;
            done_d  = owner_q ? 2'b10 : 2'b01;
            if (!wr_q && !owner_q) rdata0_d = mem_rdata_i;
            if (!wr_q && owner_q) rdata1_d = mem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         wr_q     <= 1'b0;
         last_q   <= 1'b1;
         done_q   <= 2'b00;
         cnt_q    <= '0;
         wait1_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
         last_q   <= last_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         wait1_q  <= wait1_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign m0_gnt_o    = busy & ~owner_q;
   assign m1_gnt_o    = busy & owner_q;
   assign m0_done_o   = done_q[0];
   assign m1_done_o   = done_q[1];
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;
   assign m0_stall_o  = m0_req_i & ~done_q[0];
   assign mem_rd_o    = busy & ~wr_q;
   assign mem_wr_o    = busy & wr_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: three configurations (RR lat 1, RR lat 3, priority lat 1) on shared stimulus,
// checked against a transaction-level model, a vector table and directed multi-cycle sequences.
module tb_data_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
   logic [134:0] act [3];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int L = (g == 1) ? 3 : 1;
      localparam int P = (g == 2) ? 1 : 0;
      logic        g0, d0, s0, g1, d1, rd, wr;
      logic [31:0] r0, r1, ma, mw;
      data_bus_arbiter #(.MEM_LAT(L), .PRIO_MODE(P), .MAX_WAIT(8)) dut (
         .clk(clk), .reset(reset),
         .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
         .m0_gnt_o(g0), .m0_done_o(d0), .m0_rdata_o(r0), .m0_stall_o(s0),
         .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
         .m1_gnt_o(g1), .m1_done_o(d1), .m1_rdata_o(r1),
         .mem_rd_o(rd), .mem_wr_o(wr), .mem_addr_o(ma), .mem_wdata_o(mw), .mem_rdata_i(mem_rdata)
      );
      assign act[g] = {g0, d0, r0, s0, g1, d1, r1, rd, wr, ma, mw};
   end

   // owner -1 means bus free; remain counts access cycles still to show; done_who -1 means no pulse
   typedef struct {
      int          owner;
      int          remain;
      int          done_who;
      int          last;
      int          wait1;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } mdl_t;
   mdl_t m [3];

   function automatic mdl_t step(mdl_t s, int lat, bit prio);
      mdl_t n = s;
      int w;
      if (!reset) begin
         n.owner = -1; n.remain = 0; n.done_who = -1; n.last = 1; n.wait1 = 0;
         n.wr = 1'b0; n.addr = '0; n.wdata = '0; n.rd0 = '0; n.rd1 = '0;
         return n;
      end
      n.done_who = -1;
      if (s.owner >= 0) begin
         if (s.remain == 1) begin
            if (!s.wr && s.owner == 0) n.rd0 = mem_rdata;
            if (!s.wr && s.owner == 1) n.rd1 = mem_rdata;
            n.done_who = s.owner;
            n.last = s.owner;
            n.owner = -1;
         end else n.remain = s.remain - 1;
      end else if (s.done_who < 0 && (m0_req || m1_req)) begin
         if (m0_req && m1_req) w = prio ? ((s.wait1 >= 8) ? 1 : 0) : ((s.last == 0) ? 1 : 0);
         else w = m1_req ? 1 : 0;
         n.owner = w;
         n.remain = lat;
         n.wr = w ? m1_wr : m0_wr;
         n.addr = w ? m1_addr : m0_addr;
         n.wdata = w ? m1_wdata : m0_wdata;
      end
      if (n.owner == 1 && s.owner != 1) n.wait1 = 0;
      else if (m1_req && s.done_who != 1 && s.owner != 1) n.wait1 = (s.wait1 < 8) ? s.wait1 + 1 : 8;
      return n;
   endfunction

   function automatic logic [134:0] expv(mdl_t s);
      return {s.owner == 0, s.done_who == 0, s.rd0, m0_req && s.done_who != 0,
              s.owner == 1, s.done_who == 1, s.rd1,
              s.owner >= 0 && !s.wr, s.owner >= 0 && s.wr, s.addr, s.wdata};
   endfunction

   task automatic cmp(input string nm, input logic [134:0] a, input logic [134:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      for (int g = 0; g < 3; g++) cmp($sformatf("model u%0d t=%0t", g, $time), act[g], expv(m[g]));
   endtask

   task automatic advance();
      @(posedge clk);
      for (int g = 0; g < 3; g++) m[g] = step(m[g], (g == 1) ? 3 : 1, g == 2);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m0_req = 1'b0;
      m1_req = 1'b0;
      sample();
      advance();
      reset = 1'b1;
   endtask

   typedef struct {
      bit          rn;
      bit          r0;
      logic [31:0] a0;
      logic [31:0] rdat;
      bit          e_rd;
      bit          e_done;
      bit          e_stall;
      logic [31:0] e_rdata;
      logic [31:0] e_addr;
   } vec_t;
   vec_t tbl [6];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
      tbl[1] = '{1'b1, 1'b1, 32'h40000010, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
      tbl[2] = '{1'b1, 1'b1, 32'h40000010, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0,        32'h40000010};
      tbl[3] = '{1'b1, 1'b1, 32'h40000010, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h40000010};
      tbl[4] = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h40000010};
      tbl[5] = '{1'b1, 1'b0, 32'h0,        32'h5555AAAA, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h40000010};
      reset = 1'b0;
      {m0_req, m0_wr, m1_req, m1_wr} = '0;
      {m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata} = '0;
      advance();
      advance();
      // MEM_LAT=1 single read: strobe one cycle, done the next, stall until done
      for (int i = 0; i < 6; i++) begin
         reset = tbl[i].rn;
         m0_req = tbl[i].r0;
         m0_wr = 1'b0;
         m0_addr = tbl[i].a0;
         mem_rdata = tbl[i].rdat;
         sample();
         cmp($sformatf("table row %0d", i),
             135'({u[0].rd, u[0].d0, u[0].s0, u[0].r0, u[0].ma}),
             135'({tbl[i].e_rd, tbl[i].e_done, tbl[i].e_stall, tbl[i].e_rdata, tbl[i].e_addr}));
         advance();
      end
      // both masters continuous: round-robin alternates, priority mode forces m1 once wait saturates
      do_reset();
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10; m0_wdata = '0;
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h20; m1_wdata = '0;
      for (int c = 0; c < 14; c++) begin
         mem_rdata = 32'hA000_0000 + 32'(c);
         sample();
         cmp($sformatf("rr grant c%0d", c), 135'({u[0].g0, u[0].g1, u[0].d0, u[0].d1}),
             135'({c % 3 == 1 && (c / 3) % 2 == 0, c % 3 == 1 && (c / 3) % 2 == 1,
                   c % 3 == 2 && (c / 3) % 2 == 0, c % 3 == 2 && (c / 3) % 2 == 1}));
         cmp($sformatf("prio grant c%0d", c), 135'({u[2].g0, u[2].g1}),
             135'({c % 3 == 1 && c != 10, c == 10}));
         advance();
      end
      // MEM_LAT=3 write from m1: three stable strobe cycles, done on the fourth, rdata untouched
      do_reset();
      m0_req = 1'b0;
      m1_wr = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h12345678;
      mem_rdata = 32'hBAD0BAD0;
      for (int c = 0; c < 7; c++) begin
         m1_req = c <= 4;
         sample();
         cmp($sformatf("lat3 write c%0d", c), 135'({u[1].wr, u[1].rd, u[1].ma, u[1].mw, u[1].d1, u[1].r1}),
             135'({c >= 1 && c <= 3, 1'b0, (c == 0) ? 32'h0 : 32'h100,
                   (c == 0) ? 32'h0 : 32'h12345678, c == 4, 32'h0}));
         advance();
      end
      // reset in the second access cycle aborts without a done pulse
      do_reset();
      m1_req = 1'b0;
      m0_wr = 1'b0; m0_addr = 32'h300;
      for (int c = 0; c < 7; c++) begin
         m0_req = c <= 2;
         reset = c != 2;
         sample();
         cmp($sformatf("abort c%0d", c), 135'({u[1].g0, u[1].g1, u[1].d0, u[1].d1, u[1].rd, u[1].wr, u[1].ma}),
             135'({c == 1 || c == 2, 1'b0, 1'b0, 1'b0, c == 1 || c == 2, 1'b0,
                   (c == 1 || c == 2) ? 32'h300 : 32'h0}));
         advance();
      end
      // m0 holds req through done: no grant in the done cycle, regrant decided the next cycle
      do_reset();
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h400;
      for (int c = 0; c < 6; c++) begin
         sample();
         cmp($sformatf("hold c%0d", c), 135'({u[0].g0, u[0].d0}),
             135'({c == 1 || c == 4, c == 2 || c == 5}));
         advance();
      end
      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom % 300) != 0;
         if (m0_req) m0_req = ($urandom % 6) != 0;
         else if ($urandom % 3 == 0) begin
            m0_req = 1'b1; m0_wr = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
         end
         if (m1_req) m1_req = ($urandom % 6) != 0;
         else if ($urandom % 3 == 0) begin
            m1_req = 1'b1; m1_wr = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
         end
         mem_rdata = $urandom;
         sample();
         advance();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
